// File: rtl/ibuf_pkg.sv
// Shared constants, bank state encoding and RAM address helper for the input-buffer burst sink.
package ibuf_pkg;

    localparam int unsigned DW     = 8;
    localparam int unsigned BURST  = 32;
    localparam int unsigned POY    = 3;
    localparam int unsigned STRIDE = 2;

    // Rows needed to produce POY output rows at the given stride.
    localparam int unsigned LM     = (STRIDE + 1) * POY - STRIDE;

    localparam int unsigned ROW_W  = $clog2(LM);
    localparam int unsigned COL_W  = $clog2(BURST);
    localparam int unsigned DEPTH  = 2 * LM * BURST;
    localparam int unsigned AW     = $clog2(DEPTH);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    function automatic logic [AW-1:0] ram_addr(
        input logic             bank,
        input logic [ROW_W-1:0] row,
        input logic [COL_W-1:0] col
    );
        return AW'(bank) * AW'(LM * BURST) + AW'(row) * AW'(BURST) + AW'(col);
    endfunction

endpackage

// File: rtl/ibuf_bank_ram.sv
// Two-bank row buffer storage: one write port, one registered read port (read-before-write).
module ibuf_bank_ram
    import ibuf_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read data register is cleared on reset; storage is not.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ibuf_burst_sink.sv
// Accepts AXI R beats into a ping-pong row buffer, flags full blocks and serves loader reads.
module ibuf_burst_sink
    import ibuf_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DW-1:0]    rdata_i,
    input  logic             rvalid_i,
    input  logic             rlast_i,
    output logic             rready_o,
    output logic             fill_bank_o,
    output logic [1:0]       blk_ready_o,
    input  logic             blk_release_i,
    input  logic             release_bank_i,
    input  logic             rd_en_i,
    input  logic             rd_bank_i,
    input  logic [ROW_W-1:0] rd_row_i,
    input  logic [COL_W-1:0] rd_col_i,
    output logic [DW-1:0]    rd_data_o,
    output logic             rd_valid_o,
    output logic             burst_err_o,
    input  logic             err_clr_i
);

    bank_state_t      state_q [2];
    bank_state_t      state_d [2];
    logic             fill_bank_q, fill_bank_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             ovr_q, ovr_d;
    logic [1:0]       blk_ready_q, blk_ready_d;
    logic             burst_err_q, burst_err_d;
    logic             rd_valid_q;
    logic             rready_c, accept_c, we_c, err_set_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q[0]  <= EMPTY;
            state_q[1]  <= EMPTY;
            fill_bank_q <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            ovr_q       <= 1'b0;
            blk_ready_q <= 2'b00;
            burst_err_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q[0]  <= state_d[0];
            state_q[1]  <= state_d[1];
            fill_bank_q <= fill_bank_d;
            row_q       <= row_d;
            col_q       <= col_d;
            ovr_q       <= ovr_d;
            blk_ready_q <= blk_ready_d;
            burst_err_q <= burst_err_d;
            rd_valid_q  <= rd_en_i;
        end
    end

    always_comb begin
        state_d[0]  = state_q[0];
        state_d[1]  = state_q[1];
        fill_bank_d = fill_bank_q;
        row_d       = row_q;
        col_d       = col_q;
        ovr_d       = ovr_q;
        blk_ready_d = blk_ready_q;
        err_set_c   = 1'b0;
        we_c        = 1'b0;
        rready_c    = rst_n & (state_q[fill_bank_q] != FULL);
        accept_c    = rvalid_i & rready_c;

        if (accept_c) begin
            // Once a row has overrun, further beats of that burst are dropped.
            we_c = ~ovr_q;
            if (ovr_q) begin
                err_set_c = 1'b1;
            end
            if (state_q[fill_bank_q] == EMPTY) begin
                state_d[fill_bank_q] = FILLING;
            end
            if (rlast_i) begin
                if (col_q != COL_W'(BURST - 1)) begin
                    err_set_c = 1'b1;
                end
                col_d = '0;
                ovr_d = 1'b0;
                if (row_q == ROW_W'(LM - 1)) begin
                    row_d                    = '0;
                    state_d[fill_bank_q]     = FULL;
                    blk_ready_d[fill_bank_q] = 1'b1;
                    fill_bank_d              = ~fill_bank_q;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else if (col_q == COL_W'(BURST - 1)) begin
                ovr_d = 1'b1;
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end

        // Only a FULL bank can be released; the filling bank never is FULL, so no conflict.
        if (blk_release_i && (state_q[release_bank_i] == FULL)) begin
            state_d[release_bank_i]     = EMPTY;
            blk_ready_d[release_bank_i] = 1'b0;
        end

        burst_err_d = (burst_err_q & ~err_clr_i) | err_set_c;
    end

    ibuf_bank_ram u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (we_c),
        .waddr_i (ram_addr(fill_bank_q, row_q, col_q)),
        .wdata_i (rdata_i),
        .re_i    (rd_en_i),
        .raddr_i (ram_addr(rd_bank_i, rd_row_i, rd_col_i)),
        .rdata_o (rd_data_o)
    );

    assign rready_o    = rready_c;
    assign fill_bank_o = fill_bank_q;
    assign blk_ready_o = blk_ready_q;
    assign rd_valid_o  = rd_valid_q;
    assign burst_err_o = burst_err_q;

endmodule

// File: tb/tb_ibuf_burst_sink.sv
// Directed bench for ibuf_burst_sink: block fills, back-pressure, readback table and burst-error corners.
module tb_ibuf_burst_sink;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rdata;
    logic       rvalid, rlast, rready;
    logic       fill_bank;
    logic [1:0] blk_ready;
    logic       blk_release, release_bank;
    logic       rd_en, rd_bank;
    logic [2:0] rd_row;
    logic [4:0] rd_col;
    logic [7:0] rd_data;
    logic       rd_valid, burst_err, err_clr;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic       bank;
        logic [2:0] row;
        logic [4:0] col;
        logic [7:0] exp;
    } rd_vec_t;

    rd_vec_t vt [8];

    always #5 clk = ~clk;

    ibuf_burst_sink dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rdata_i        (rdata),
        .rvalid_i       (rvalid),
        .rlast_i        (rlast),
        .rready_o       (rready),
        .fill_bank_o    (fill_bank),
        .blk_ready_o    (blk_ready),
        .blk_release_i  (blk_release),
        .release_bank_i (release_bank),
        .rd_en_i        (rd_en),
        .rd_bank_i      (rd_bank),
        .rd_row_i       (rd_row),
        .rd_col_i       (rd_col),
        .rd_data_o      (rd_data),
        .rd_valid_o     (rd_valid),
        .burst_err_o    (burst_err),
        .err_clr_i      (err_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last);
        int n = 0;
        rdata  = d;
        rlast  = last;
        rvalid = 1'b1;
        while (!rready && n < 1000) begin
            step();
            n++;
        end
        if (!rready) begin
            check("beat_wait_timeout", 32'(rready), 32'd1);
        end
        step();
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic send_beats(input int count, input int base);
        for (int i = 0; i < count; i++) begin
            send_beat(8'(base + i), (i % 32) == 31);
        end
    endtask

    task automatic do_read(input string name, input logic b, input logic [2:0] r,
                           input logic [4:0] c, input logic [7:0] exp);
        rd_en  = 1'b1;
        rd_bank = b;
        rd_row = r;
        rd_col = c;
        step();
        rd_en = 1'b0;
        check({name, "_valid"}, 32'(rd_valid), 32'd1);
        check(name, 32'(rd_data), 32'(exp));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_blk_ready"}, 32'(blk_ready), 32'd0);
        check({tag, "_fill_bank"}, 32'(fill_bank), 32'd0);
        check({tag, "_rd_valid"},  32'(rd_valid),  32'd0);
        check({tag, "_rd_data"},   32'(rd_data),   32'd0);
        check({tag, "_burst_err"}, 32'(burst_err), 32'd0);
    endtask

    initial begin
        vt[0] = '{1'b0, 3'd3, 5'd5,  8'd101};
        vt[1] = '{1'b0, 3'd0, 5'd0,  8'd0};
        vt[2] = '{1'b0, 3'd6, 5'd31, 8'd223};
        vt[3] = '{1'b0, 3'd1, 5'd31, 8'd63};
        vt[4] = '{1'b1, 3'd0, 5'd0,  8'd224};
        vt[5] = '{1'b1, 3'd0, 5'd31, 8'd255};
        vt[6] = '{1'b1, 3'd1, 5'd0,  8'd0};
        vt[7] = '{1'b1, 3'd6, 5'd31, 8'd191};

        rst_n = 1'b0; rdata = '0; rvalid = 1'b0; rlast = 1'b0;
        blk_release = 1'b0; release_bank = 1'b0; rd_en = 1'b0;
        rd_bank = 1'b0; rd_row = '0; rd_col = '0; err_clr = 1'b0;
        #1;
        check("rready_in_reset", 32'(rready), 32'd0);
        step();
        step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        #1;
        check("rready_after_reset", 32'(rready), 32'd1);

        // Block fill into bank0, data = beat index.
        send_beats(223, 0);
        check("blk_ready_before_last", 32'(blk_ready), 32'd0);
        send_beat(8'd223, 1'b1);
        check("blk_ready_fill0", 32'(blk_ready), 32'd1);
        check("fill_bank_fill0", 32'(fill_bank), 32'd1);
        check("rready_fill0", 32'(rready), 32'd1);
        check("burst_err_fill0", 32'(burst_err), 32'd0);

        // Second block fills bank1; both full stalls the channel.
        send_beats(224, 224);
        check("blk_ready_both", 32'(blk_ready), 32'd3);
        check("rready_both_full", 32'(rready), 32'd0);
        check("fill_bank_both", 32'(fill_bank), 32'd0);
        rvalid = 1'b1; rdata = 8'hEE;
        step();
        step();
        check("rready_stall", 32'(rready), 32'd0);
        rvalid = 1'b0;

        // Back-to-back readback table, one result per cycle.
        for (int i = 0; i < 8; i++) begin
            rd_en   = 1'b1;
            rd_bank = vt[i].bank;
            rd_row  = vt[i].row;
            rd_col  = vt[i].col;
            step();
            check($sformatf("rd_valid_vec%0d", i), 32'(rd_valid), 32'd1);
            check($sformatf("rd_data_vec%0d", i), 32'(rd_data), 32'(vt[i].exp));
        end
        rd_en = 1'b0;
        step();
        check("rd_valid_idle", 32'(rd_valid), 32'd0);
        check("rd_data_hold", 32'(rd_data), 32'(vt[7].exp));

        // Release of bank0 reopens the channel next cycle.
        blk_release = 1'b1; release_bank = 1'b0;
        step();
        blk_release = 1'b0;
        check("blk_ready_release", 32'(blk_ready), 32'd2);
        check("rready_release", 32'(rready), 32'd1);
        blk_release = 1'b1; release_bank = 1'b0;
        step();
        blk_release = 1'b0;
        check("blk_ready_release_empty", 32'(blk_ready), 32'd2);
        send_beat(8'hA5, 1'b0);
        do_read("after_release_r0c0", 1'b0, 3'd0, 5'd0, 8'hA5);
        do_read("after_release_r0c1_old", 1'b0, 3'd0, 5'd1, 8'd1);

        // Reset mid-fill after 100 beats in total.
        for (int i = 1; i < 100; i++) begin
            send_beat(8'(i), (i % 32) == 31);
        end
        rst_n = 1'b0;
        #1;
        check("rready_mid_reset", 32'(rready), 32'd0);
        step();
        check_reset_outputs("mid_reset");
        rst_n = 1'b1;
        send_beats(224, 7);
        check("blk_ready_after_reset_fill", 32'(blk_ready), 32'd1);
        check("fill_bank_after_reset_fill", 32'(fill_bank), 32'd1);
        do_read("reset_fill_r0c0", 1'b0, 3'd0, 5'd0, 8'd7);
        do_read("reset_fill_r6c31", 1'b0, 3'd6, 5'd31, 8'd230);

        // Early rlast on beat 20 of the first burst in bank1.
        for (int i = 0; i < 20; i++) begin
            send_beat(8'(8'h40 + i), i == 19);
        end
        check("burst_err_early", 32'(burst_err), 32'd1);
        send_beat(8'h77, 1'b0);
        do_read("early_next_r1c0", 1'b1, 3'd1, 5'd0, 8'h77);
        do_read("early_r0c19", 1'b1, 3'd0, 5'd19, 8'h53);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("burst_err_cleared", 32'(burst_err), 32'd0);

        // Finish row1 cleanly (col1..col31, rlast on col31).
        for (int i = 1; i < 32; i++) begin
            send_beat(8'(i), i == 31);
        end
        check("burst_err_clean_row", 32'(burst_err), 32'd0);

        // Overrun: 34 beats into row2, clear requested on the first dropped beat.
        for (int i = 0; i < 34; i++) begin
            err_clr = (i == 32);
            send_beat(8'(8'h80 + i), i == 33);
        end
        err_clr = 1'b0;
        check("burst_err_overrun", 32'(burst_err), 32'd1);
        do_read("overrun_r2c31", 1'b1, 3'd2, 5'd31, 8'h9F);
        do_read("overrun_r2c0", 1'b1, 3'd2, 5'd0, 8'h80);
        send_beat(8'h55, 1'b0);
        do_read("overrun_next_r3c0", 1'b1, 3'd3, 5'd0, 8'h55);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
